// File: rtl/dds_sweep_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Drives the DDS core control inputs (Enable, LoadP, LoadF, FreqPhase) to run
// a stepped frequency sweep. A start pulse latches the sweep configuration and
// loads the initial phase. A series of frequency words spaced by a fixed step
// is then loaded, and each word is held for a programmable dwell time.
//
// Optional build macro:
//   SWEEP_CONTINUOUS_EN - adds input cfg_loop. When the latched cfg_loop is 1
//                         the sweep restarts from the start frequency after the
//                         last point (without reloading the phase) and runs
//                         until abort. done is never pulsed in that mode.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   start           single-cycle sweep start request (ignored while busy)
//   abort           synchronous abort, returns to IDLE from any other state
//   cfg_start_freq  first frequency word
//   cfg_step        unsigned frequency increment per point (wraps mod 2^FW)
//   cfg_num_steps   number of frequency points, 0 treated as 1
//   cfg_dwell       clk cycles per point, 0 treated as 1
//   cfg_phase       initial phase word
//   cfg_loop        (SWEEP_CONTINUOUS_EN only) continuous sweep select
//   dds_enable      DDS Enable
//   dds_loadp       DDS LoadP, 1-cycle pulse
//   dds_loadf       DDS LoadF, 1-cycle pulse
//   dds_freqphase   DDS FreqPhase
//   busy            high in LOAD_P, LOAD_F and DWELL
//   done            1-cycle pulse at sweep completion
//   step_idx        0-based index of the current frequency point
//
// All outputs are registered: the next-state logic computes the output values
// belonging to the state being entered, so they change together with state.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int FW      = 16,
    parameter int CNT_W   = 10,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FW-1:0]      cfg_start_freq,
    input  logic [FW-1:0]      cfg_step,
    input  logic [CNT_W-1:0]   cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [FW-1:0]      cfg_phase,
`ifdef SWEEP_CONTINUOUS_EN
    input  logic               cfg_loop,
`endif
    output logic               dds_enable,
    output logic               dds_loadp,
    output logic               dds_loadf,
    output logic [FW-1:0]      dds_freqphase,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_P = 3'd1,
        S_LOAD_F = 3'd2,
        S_DWELL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Index of the last point; a zero point count behaves as a single point.
    function automatic logic [CNT_W-1:0] last_index(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] r;
        if (n == {CNT_W{1'b0}}) begin
            r = {CNT_W{1'b0}};
        end else begin
            r = n - CNT_W'(1);
        end
        return r;
    endfunction

    // Effective dwell; a zero dwell behaves as one cycle.
    function automatic logic [DWELL_W-1:0] dwell_eff(input logic [DWELL_W-1:0] d);
        logic [DWELL_W-1:0] r;
        if (d == {DWELL_W{1'b0}}) begin
            r = DWELL_W'(1);
        end else begin
            r = d;
        end
        return r;
    endfunction

    state_t             state_q,     state_d;
    logic               enable_q,    enable_d;
    logic               loadp_q,     loadp_d;
    logic               loadf_q,     loadf_d;
    logic               done_q,      done_d;
    logic               busy_q,      busy_d;
    logic [FW-1:0]      freqphase_q, freqphase_d;
    logic [CNT_W-1:0]   step_idx_q,  step_idx_d;
    logic [FW-1:0]      cur_freq_q,  cur_freq_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

    // Shadow copies of the configuration, frozen for the whole sweep.
    logic [FW-1:0]      step_sh_q,     step_sh_d;
    logic [CNT_W-1:0]   last_idx_sh_q, last_idx_sh_d;
    logic [DWELL_W-1:0] dwell_sh_q,    dwell_sh_d;
`ifdef SWEEP_CONTINUOUS_EN
    logic [FW-1:0]      start_sh_q,    start_sh_d;
    logic               loop_sh_q,     loop_sh_d;
`endif

    logic [FW-1:0]      next_freq_s;

    // Frequency of the following point; unsigned add wraps silently.
    always_comb begin
        next_freq_s = cur_freq_q + step_sh_q;
    end

    // Next-state and next-output logic of the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        enable_d      = 1'b0;
        loadp_d       = 1'b0;
        loadf_d       = 1'b0;
        done_d        = 1'b0;
        busy_d        = 1'b0;
        freqphase_d   = freqphase_q;
        step_idx_d    = step_idx_q;
        cur_freq_d    = cur_freq_q;
        dwell_cnt_d   = dwell_cnt_q;
        step_sh_d     = step_sh_q;
        last_idx_sh_d = last_idx_sh_q;
        dwell_sh_d    = dwell_sh_q;
`ifdef SWEEP_CONTINUOUS_EN
        start_sh_d    = start_sh_q;
        loop_sh_d     = loop_sh_q;
`endif

        case (state_q)
            S_IDLE: begin
                // abort takes priority over a simultaneous start
                if (start && !abort) begin
                    state_d       = S_LOAD_P;
                    step_sh_d     = cfg_step;
                    last_idx_sh_d = last_index(cfg_num_steps);
                    dwell_sh_d    = dwell_eff(cfg_dwell);
                    cur_freq_d    = cfg_start_freq;
                    step_idx_d    = {CNT_W{1'b0}};
`ifdef SWEEP_CONTINUOUS_EN
                    start_sh_d    = cfg_start_freq;
                    loop_sh_d     = cfg_loop;
`endif
                    loadp_d       = 1'b1;
                    enable_d      = 1'b1;
                    busy_d        = 1'b1;
                    freqphase_d   = cfg_phase;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_LOAD_P: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_LOAD_F;
                    loadf_d     = 1'b1;
                    enable_d    = 1'b1;
                    busy_d      = 1'b1;
                    freqphase_d = cur_freq_q;
                end
            end

            S_LOAD_F: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_DWELL;
                    enable_d    = 1'b1;
                    busy_d      = 1'b1;
                    dwell_cnt_d = dwell_sh_q;
                end
            end

            S_DWELL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_cnt_q > DWELL_W'(1)) begin
                    state_d     = S_DWELL;
                    enable_d    = 1'b1;
                    busy_d      = 1'b1;
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else if (step_idx_q == last_idx_sh_q) begin
`ifdef SWEEP_CONTINUOUS_EN
                    if (loop_sh_q) begin
                        // wrap back to the first point; phase is not reloaded
                        state_d     = S_LOAD_F;
                        loadf_d     = 1'b1;
                        enable_d    = 1'b1;
                        busy_d      = 1'b1;
                        cur_freq_d  = start_sh_q;
                        freqphase_d = start_sh_q;
                        step_idx_d  = {CNT_W{1'b0}};
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d     = S_LOAD_F;
                    loadf_d     = 1'b1;
                    enable_d    = 1'b1;
                    busy_d      = 1'b1;
                    cur_freq_d  = next_freq_s;
                    freqphase_d = next_freq_s;
                    step_idx_d  = step_idx_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, output and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            enable_q      <= 1'b0;
            loadp_q       <= 1'b0;
            loadf_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            freqphase_q   <= {FW{1'b0}};
            step_idx_q    <= {CNT_W{1'b0}};
            cur_freq_q    <= {FW{1'b0}};
            dwell_cnt_q   <= {DWELL_W{1'b0}};
            step_sh_q     <= {FW{1'b0}};
            last_idx_sh_q <= {CNT_W{1'b0}};
            dwell_sh_q    <= {DWELL_W{1'b0}};
`ifdef SWEEP_CONTINUOUS_EN
            start_sh_q    <= {FW{1'b0}};
            loop_sh_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            loadp_q       <= loadp_d;
            loadf_q       <= loadf_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            freqphase_q   <= freqphase_d;
            step_idx_q    <= step_idx_d;
            cur_freq_q    <= cur_freq_d;
            dwell_cnt_q   <= dwell_cnt_d;
            step_sh_q     <= step_sh_d;
            last_idx_sh_q <= last_idx_sh_d;
            dwell_sh_q    <= dwell_sh_d;
`ifdef SWEEP_CONTINUOUS_EN
            start_sh_q    <= start_sh_d;
            loop_sh_q     <= loop_sh_d;
`endif
        end
    end

    assign dds_enable    = enable_q;
    assign dds_loadp     = loadp_q;
    assign dds_loadf     = loadf_q;
    assign dds_freqphase = freqphase_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign step_idx      = step_idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for dds_sweep_ctrl. Expected load/done events are pushed
// into a scoreboard queue when a sweep is started and popped when the DUT
// pulses loadp/loadf/done. Cycle labels: the cycle right after the edge that
// samples start is cycle 1 of that sweep.
module tb_dds_sweep_ctrl;

    localparam int FW      = 16;
    localparam int CNT_W   = 10;
    localparam int DWELL_W = 16;

    typedef struct {
        int             kind;   // 0 loadp, 1 loadf, 2 done
        int             cyc;    // absolute cycle label
        logic [FW-1:0]  val;    // expected dds_freqphase
        logic [CNT_W-1:0] idx;  // expected step_idx
    } ev_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [FW-1:0]      cfg_start_freq;
    logic [FW-1:0]      cfg_step;
    logic [CNT_W-1:0]   cfg_num_steps;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [FW-1:0]      cfg_phase;
`ifdef SWEEP_CONTINUOUS_EN
    logic               cfg_loop;
`endif
    logic               dds_enable;
    logic               dds_loadp;
    logic               dds_loadf;
    logic [FW-1:0]      dds_freqphase;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   step_idx;

    ev_t              sb_q[$];
    int               cyc = 0;
    int               s_cyc = 0;
    int               en_lo = 1;
    int               en_hi = 0;
    bit               mon_en = 1'b0;
    logic [FW-1:0]    last_val;
    logic [CNT_W-1:0] last_idx;
    int               n_checks = 0;
    int               n_pass = 0;

    dds_sweep_ctrl #(.FW(FW), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_start_freq (cfg_start_freq),
        .cfg_step       (cfg_step),
        .cfg_num_steps  (cfg_num_steps),
        .cfg_dwell      (cfg_dwell),
        .cfg_phase      (cfg_phase),
`ifdef SWEEP_CONTINUOUS_EN
        .cfg_loop       (cfg_loop),
`endif
        .dds_enable     (dds_enable),
        .dds_loadp      (dds_loadp),
        .dds_loadf      (dds_loadf),
        .dds_freqphase  (dds_freqphase),
        .busy           (busy),
        .done           (done),
        .step_idx       (step_idx)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle label counter; stable when sampled on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic pop_event(input int kind, input int c);
        ev_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = sb_q.pop_front();
            check_eq("ev_kind",  32'(kind), 32'(e.kind));
            check_eq("ev_cycle", 32'(c), 32'(e.cyc));
            check_eq("ev_value", 32'(dds_freqphase), 32'(e.val));
            check_eq("ev_idx",   32'(step_idx), 32'(e.idx));
        end
    endtask

    // Monitor: enable/busy window every cycle, load/done pulses vs scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("enable", 32'(dds_enable), 32'(cyc >= en_lo && cyc <= en_hi));
            check_eq("busy",   32'(busy),       32'(cyc >= en_lo && cyc <= en_hi));
            if (dds_loadp) pop_event(0, cyc);
            if (dds_loadf) pop_event(1, cyc);
            if (done)      pop_event(2, cyc);
        end
    end

    task automatic randomize_cfg();
        cfg_start_freq = 16'($urandom);
        cfg_step       = 16'($urandom);
        cfg_num_steps  = 10'($urandom);
        cfg_dwell      = 16'($urandom);
        cfg_phase      = 16'($urandom);
    endtask

    // Starts a sweep at the current falling edge, pushes expected events, then
    // runs until a few cycles past its end, optionally pulsing start or abort
    // during the given sweep cycle (-1 = never).
    task automatic run_sweep(input logic [FW-1:0] f0, input logic [FW-1:0] stp,
                             input int n, input int d, input logic [FW-1:0] ph,
                             input int abort_at, input int start_again, input bit loop);
        int  ne, de, pts, rel, end_rel, kk;
        ev_t e;
        ne    = (n == 0) ? 1 : n;
        de    = (d == 0) ? 1 : d;
        s_cyc = cyc;
        e.kind = 0; e.cyc = s_cyc + 1; e.val = ph; e.idx = '0;
        sb_q.push_back(e);
        last_val = ph;
        last_idx = '0;
        pts = loop ? 4096 : ne;
        for (int k = 0; k < pts; k++) begin
            rel = 2 + k * (de + 1);
            if (abort_at >= 0 && rel > abort_at) break;
            kk = k % ne;
            e.kind = 1; e.cyc = s_cyc + rel; e.val = f0 + 16'(kk) * stp; e.idx = 10'(kk);
            sb_q.push_back(e);
            last_val = e.val;
            last_idx = e.idx;
        end
        if (!loop && (abort_at < 0 || 2 + ne * (de + 1) <= abort_at)) begin
            e.kind = 2; e.cyc = s_cyc + 2 + ne * (de + 1); e.val = last_val; e.idx = last_idx;
            sb_q.push_back(e);
        end
        en_lo = s_cyc + 1;
        en_hi = s_cyc + 1 + ne * (de + 1);
        if (abort_at >= 0 && (loop || abort_at < 1 + ne * (de + 1))) en_hi = s_cyc + abort_at;
        end_rel = (abort_at >= 0) ? abort_at + 3 : 2 + ne * (de + 1) + 3;

        cfg_start_freq = f0;
        cfg_step       = stp;
        cfg_num_steps  = 10'(n);
        cfg_dwell      = 16'(d);
        cfg_phase      = ph;
`ifdef SWEEP_CONTINUOUS_EN
        cfg_loop       = loop;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        randomize_cfg();
        for (int r = 1; r <= end_rel; r++) begin
            start = (r == start_again);
            abort = (r == abort_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        check_eq("hold_idx",   32'(step_idx), 32'(last_idx));
        check_eq("hold_fp",    32'(dds_freqphase), 32'(last_val));
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_enable"}, 32'(dds_enable), 32'd0);
        check_eq({pfx, "_loadp"},  32'(dds_loadp), 32'd0);
        check_eq({pfx, "_loadf"},  32'(dds_loadf), 32'd0);
        check_eq({pfx, "_done"},   32'(done), 32'd0);
        check_eq({pfx, "_busy"},   32'(busy), 32'd0);
        check_eq({pfx, "_fp"},     32'(dds_freqphase), 32'd0);
        check_eq({pfx, "_idx"},    32'(step_idx), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_start_freq = '0;
        cfg_step = '0;
        cfg_num_steps = '0;
        cfg_dwell = '0;
        cfg_phase = '0;
`ifdef SWEEP_CONTINUOUS_EN
        cfg_loop = 1'b0;
`endif
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // basic sweep, with a stray start during the first dwell
        run_sweep(16'h1000, 16'h0100, 3, 4, 16'h0040, -1, 4, 1'b0);
        // zero point count and zero dwell
        run_sweep(16'h1234, 16'h0010, 0, 0, 16'h0000, -1, -1, 1'b0);
        // frequency wrap
        run_sweep(16'hFF80, 16'h0100, 2, 3, 16'h7777, -1, -1, 1'b0);
        // abort in DWELL
        run_sweep(16'h1000, 16'h0100, 3, 4, 16'h0040, 5, -1, 1'b0);
        // abort in LOAD_P
        run_sweep(16'h2222, 16'h0001, 4, 2, 16'h0ABC, 1, -1, 1'b0);
        // abort coinciding with the DONE cycle
        run_sweep(16'h0500, 16'h0020, 2, 1, 16'h0003, 6, -1, 1'b0);

        // start and abort together in IDLE: nothing happens
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_abort_busy", 32'(busy), 32'd0);
        check_eq("idle_abort_sb",   32'(sb_q.size()), 32'd0);

        // asynchronous reset in the middle of a dwell
        mon_en = 1'b0;
        cfg_start_freq = 16'h3000;
        cfg_step = 16'h0011;
        cfg_num_steps = 10'd2;
        cfg_dwell = 16'd8;
        cfg_phase = 16'h0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        en_lo = 1;
        en_hi = 0;
        @(negedge clk);
        mon_en = 1'b1;
        run_sweep(16'h4000, 16'h0200, 2, 2, 16'h0055, -1, -1, 1'b0);

`ifdef SWEEP_CONTINUOUS_EN
        run_sweep(16'h0020, 16'h0010, 2, 2, 16'h0005, 20, -1, 1'b1);
`endif

        // a few random short sweeps
        for (int i = 0; i < 4; i++) begin
            run_sweep(16'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), 16'($urandom), -1, -1, 1'b0);
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
